// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX stage: ALU/writeback/forward selectors and the
// packed ID/EX register image.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] imm;
    alu_op_e           alu_op;
    logic              opa_sel;
    logic              opb_sel;
    logic              rd_wren;
    logic              mem_wren;
    logic              mem_rden;
    wb_sel_e           wb_sel;
  } id_ex_t;

  // A later stage supplies a source only when it writes a nonzero matching rd.
  function automatic logic fwd_hit(input logic              wren,
                                   input logic [REG_AW-1:0] wr_addr,
                                   input logic [REG_AW-1:0] rs_addr);
    return wren && (wr_addr != '0) && (wr_addr == rs_addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand forwarding: EX/MEM over MEM/WB over register data, x0 reads 0.
// Purely combinational; no flow control.
module fwd_mux
  import pipeline_pkg::*;
#(
  parameter int XLEN = DATA_W,
  parameter int AW   = REG_AW
) (
  input  logic [AW-1:0]   i_rs_addr,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic [AW-1:0]   i_exm_rd_addr,
  input  logic            i_exm_rd_wren,
  input  logic [XLEN-1:0] i_exm_data,
  input  logic [AW-1:0]   i_mwb_rd_addr,
  input  logic            i_mwb_rd_wren,
  input  logic [XLEN-1:0] i_mwb_data,
  output logic [XLEN-1:0] o_data,
  output fwd_sel_e        o_sel
);

  always_comb begin
    o_data = i_rs_data;
    o_sel  = FWD_REG;
    if (i_rs_addr == '0) begin
      o_data = '0;
    end else if (fwd_hit(i_exm_rd_wren, i_exm_rd_addr, i_rs_addr)) begin
      o_data = i_exm_data;
      o_sel  = FWD_EXM;
    end else if (fwd_hit(i_mwb_rd_wren, i_mwb_rd_addr, i_rs_addr)) begin
      o_data = i_mwb_data;
      o_sel  = FWD_MWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding operand muxes and load-use detect; 1-cycle latency.
// Stall holds every field, flush (winning over stall) loads a bubble with enables cleared.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN    = DATA_W,
  parameter int AW      = REG_AW,
  parameter int ALUOP_W = OP_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [AW-1:0]      i_rs1_addr,
  input  logic [AW-1:0]      i_rs2_addr,
  input  logic               i_rs1_used,
  input  logic               i_rs2_used,
  input  logic [AW-1:0]      i_rd_addr,
  input  logic [XLEN-1:0]    i_rs1_data,
  input  logic [XLEN-1:0]    i_rs2_data,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic               i_opa_sel,
  input  logic               i_opb_sel,
  input  logic               i_rd_wren,
  input  logic               i_mem_wren,
  input  logic               i_mem_rden,
  input  logic [1:0]         i_wb_sel,
  input  logic [AW-1:0]      i_exm_rd_addr,
  input  logic               i_exm_rd_wren,
  input  logic [XLEN-1:0]    i_exm_data,
  input  logic [AW-1:0]      i_mwb_rd_addr,
  input  logic               i_mwb_rd_wren,
  input  logic [XLEN-1:0]    i_mwb_data,
  output logic               o_valid,
  output logic [XLEN-1:0]    o_pc,
  output logic [AW-1:0]      o_rd_addr,
  output logic [XLEN-1:0]    o_imm,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_rd_wren,
  output logic               o_mem_wren,
  output logic               o_mem_rden,
  output logic [1:0]         o_wb_sel,
  output logic [XLEN-1:0]    o_operand_a,
  output logic [XLEN-1:0]    o_operand_b,
  output logic [XLEN-1:0]    o_store_data,
  output logic [1:0]         o_fwd_a,
  output logic [1:0]         o_fwd_b,
  output logic               o_load_use
);

  id_ex_t          r_stage;
  id_ex_t          w_next;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  fwd_sel_e        w_fwd_a_sel;
  fwd_sel_e        w_fwd_b_sel;

  // Enables of an empty decode slot are dropped at capture so nothing downstream acts on it.
  always_comb begin
    w_next          = '0;
    w_next.valid    = i_valid;
    w_next.pc       = i_pc;
    w_next.rs1_addr = i_rs1_addr;
    w_next.rs2_addr = i_rs2_addr;
    w_next.rs1_data = i_rs1_data;
    w_next.rs2_data = i_rs2_data;
    w_next.rd_addr  = i_rd_addr;
    w_next.imm      = i_imm;
    w_next.alu_op   = alu_op_e'(i_alu_op);
    w_next.opa_sel  = i_opa_sel;
    w_next.opb_sel  = i_opb_sel;
    w_next.rd_wren  = i_rd_wren  & i_valid;
    w_next.mem_wren = i_mem_wren & i_valid;
    w_next.mem_rden = i_mem_rden & i_valid;
    w_next.wb_sel   = wb_sel_e'(i_wb_sel);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stage <= '0;
    end else if (i_flush) begin
      r_stage <= '0;
    end else if (!i_stall) begin
      r_stage <= w_next;
    end
  end

  fwd_mux #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_fwd_rs1 (
    .i_rs_addr     (r_stage.rs1_addr),
    .i_rs_data     (r_stage.rs1_data),
    .i_exm_rd_addr (i_exm_rd_addr),
    .i_exm_rd_wren (i_exm_rd_wren),
    .i_exm_data    (i_exm_data),
    .i_mwb_rd_addr (i_mwb_rd_addr),
    .i_mwb_rd_wren (i_mwb_rd_wren),
    .i_mwb_data    (i_mwb_data),
    .o_data        (w_rs1_fwd),
    .o_sel         (w_fwd_a_sel)
  );

  fwd_mux #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_fwd_rs2 (
    .i_rs_addr     (r_stage.rs2_addr),
    .i_rs_data     (r_stage.rs2_data),
    .i_exm_rd_addr (i_exm_rd_addr),
    .i_exm_rd_wren (i_exm_rd_wren),
    .i_exm_data    (i_exm_data),
    .i_mwb_rd_addr (i_mwb_rd_addr),
    .i_mwb_rd_wren (i_mwb_rd_wren),
    .i_mwb_data    (i_mwb_data),
    .o_data        (w_rs2_fwd),
    .o_sel         (w_fwd_b_sel)
  );

  assign o_valid      = r_stage.valid;
  assign o_pc         = r_stage.pc;
  assign o_rd_addr    = r_stage.rd_addr;
  assign o_imm        = r_stage.imm;
  assign o_alu_op     = r_stage.alu_op;
  assign o_rd_wren    = r_stage.rd_wren;
  assign o_mem_wren   = r_stage.mem_wren;
  assign o_mem_rden   = r_stage.mem_rden;
  assign o_wb_sel     = r_stage.wb_sel;

  // operand_b[4:0] doubles as the shift amount, so it must carry the forwarded value too.
  assign o_operand_a  = r_stage.opa_sel ? r_stage.pc  : w_rs1_fwd;
  assign o_operand_b  = r_stage.opb_sel ? r_stage.imm : w_rs2_fwd;
  assign o_store_data = w_rs2_fwd;
  assign o_fwd_a      = w_fwd_a_sel;
  assign o_fwd_b      = w_fwd_b_sel;

  assign o_load_use = r_stage.valid & r_stage.mem_rden & (r_stage.rd_addr != '0) &
                      ((i_rs1_used & (i_rs1_addr == r_stage.rd_addr)) |
                       (i_rs2_used & (i_rs2_addr == r_stage.rd_addr)));

endmodule
